// File: rtl/pit_table.sv
// pit_table: pending interest table upstream of fib.
// Optional entry expiry is enabled by defining PIT_TIMEOUT_EN.
module pit_table #(
  parameter int ENTRIES       = 8,
  parameter int FACES         = 4,
  parameter int HOLD_CYCLES   = 4,
  parameter int PAYLOAD_BYTES = 8,
  parameter int LIFETIME      = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     interest_valid,
  input  logic [63:0]              interest_prefix,
  input  logic [5:0]               interest_len,
  input  logic [$clog2(FACES)-1:0] interest_face,
  output logic                     interest_ready,
  output logic                     interest_drop,
  output logic [63:0]              pit_in_prefix,
  output logic [5:0]               pit_in_len,
  output logic                     fib_out_bit,
  input  logic                     prefix_ready,
  input  logic [63:0]              pit_out_prefix,
  input  logic [5:0]               pit_out_len,
  input  logic [7:0]               out_data,
  output logic                     start_send_to_pit,
  output logic                     rejected,
  output logic                     down_valid,
  output logic [7:0]               down_data,
  output logic [FACES-1:0]         down_face_mask
);

  localparam int IW = $clog2(ENTRIES);
  localparam int FW = $clog2(FACES);

  typedef enum logic [1:0] {
    I_IDLE,
    I_LOOKUP,
    I_FWD
  } i_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LOOKUP,
    D_STREAM
  } d_state_t;

  i_state_t i_state, i_next;
  d_state_t d_state, d_next;

  logic [63:0]      i_pfx;
  logic [5:0]       i_len;
  logic [FW-1:0]    i_face;
  logic [3:0]       i_cnt;
  logic [FACES-1:0] face_bit;

  logic [63:0]      d_pfx;
  logic [5:0]       d_len;
  logic [IW-1:0]    d_idx;
  logic [FACES-1:0] d_mask;
  logic [8:0]       d_cnt;

  logic [ENTRIES-1:0] e_vld;
  logic [ENTRIES-1:0] e_lck;
  logic [ENTRIES-1:0] e_exp;
  logic [63:0]        e_pfx  [ENTRIES];
  logic [5:0]         e_len  [ENTRIES];
  logic [FACES-1:0]   e_mask [ENTRIES];

  logic          d_hit;
  logic [IW-1:0] d_hidx;
  logic          d_take;
  logic          d_done;
  logic          i_hit;
  logic [IW-1:0] i_idx;
  logic          i_has_free;
  logic [IW-1:0] i_free;
  logic          i_alloc;
  logic          i_agg;
  logic          i_full;

  assign face_bit = FACES'(1) << i_face;

  // Lookups: lowest-index match for both FSMs, lowest free slot.
  always_comb begin
    d_hit      = 1'b0;
    d_hidx     = '0;
    i_hit      = 1'b0;
    i_idx      = '0;
    i_has_free = 1'b0;
    i_free     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (e_vld[i] && !e_lck[i] && !e_exp[i]
          && e_pfx[i] == d_pfx && e_len[i] == d_len) begin
        d_hit  = 1'b1;
        d_hidx = IW'(i);
      end
    end
    d_take = (d_state == D_LOOKUP) && d_hit;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (e_vld[i] && !e_lck[i] && !e_exp[i]
          && !(d_take && d_hidx == IW'(i))
          && e_pfx[i] == i_pfx && e_len[i] == i_len) begin
        i_hit = 1'b1;
        i_idx = IW'(i);
      end
      if (!e_vld[i]) begin
        i_has_free = 1'b1;
        i_free     = IW'(i);
      end
    end
  end

  assign i_alloc = (i_state == I_LOOKUP) && !i_hit && i_has_free;
  assign i_agg   = (i_state == I_LOOKUP) && i_hit;
  assign i_full  = (i_state == I_LOOKUP) && !i_hit && !i_has_free;
  assign d_done  = (d_state == D_STREAM)
                   && d_cnt == 9'(PAYLOAD_BYTES);

  // Interest FSM next state.
  always_comb begin
    i_next = i_state;
    unique case (i_state)
      I_IDLE:   if (interest_valid) i_next = I_LOOKUP;
      I_LOOKUP: i_next = i_alloc ? I_FWD : I_IDLE;
      I_FWD:
        if (i_cnt == 4'(HOLD_CYCLES - 1)) i_next = I_IDLE;
      default:  i_next = I_IDLE;
    endcase
  end

  // Interest FSM registers and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_state       <= I_IDLE;
      i_cnt         <= '0;
      i_pfx         <= '0;
      i_len         <= '0;
      i_face        <= '0;
      interest_drop <= 1'b0;
    end else begin
      i_state       <= i_next;
      interest_drop <= i_full;
      i_cnt         <= (i_state == I_FWD) ? i_cnt + 4'd1 : 4'd0;
      if (i_state == I_IDLE && interest_valid) begin
        i_pfx  <= interest_prefix;
        i_len  <= interest_len;
        i_face <= interest_face;
      end
    end
  end

  assign interest_ready = (i_state == I_IDLE) && !rst;
  assign fib_out_bit    = (i_state == I_FWD);
  assign pit_in_prefix  = fib_out_bit ? i_pfx : 64'd0;
  assign pit_in_len     = fib_out_bit ? i_len : 6'd0;

  // Data FSM next state.
  always_comb begin
    d_next = d_state;
    unique case (d_state)
      D_IDLE:   if (prefix_ready) d_next = D_LOOKUP;
      D_LOOKUP: d_next = d_hit ? D_STREAM : D_IDLE;
      D_STREAM: if (d_done) d_next = D_IDLE;
      default:  d_next = D_IDLE;
    endcase
  end

  // Data FSM registers, handshake pulses and payload fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_state           <= D_IDLE;
      d_pfx             <= '0;
      d_len             <= '0;
      d_idx             <= '0;
      d_mask            <= '0;
      d_cnt             <= '0;
      start_send_to_pit <= 1'b0;
      rejected          <= 1'b0;
      down_valid        <= 1'b0;
      down_data         <= '0;
      down_face_mask    <= '0;
    end else begin
      d_state           <= d_next;
      start_send_to_pit <= d_take;
      rejected          <= (d_state == D_LOOKUP) && !d_hit;
      d_cnt <= (d_state == D_STREAM) ? d_cnt + 9'd1 : 9'd0;
      if (d_state == D_IDLE && prefix_ready) begin
        d_pfx <= pit_out_prefix;
        d_len <= pit_out_len;
      end
      if (d_take) begin
        d_idx  <= d_hidx;
        d_mask <= e_mask[d_hidx];
      end
      if (d_state == D_STREAM && d_cnt != 9'd0) begin
        down_valid     <= 1'b1;
        down_data      <= out_data;
        down_face_mask <= d_mask;
      end else begin
        down_valid     <= 1'b0;
        down_data      <= '0;
        down_face_mask <= '0;
      end
    end
  end

  // Entry valid/lock bits; data side writes last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_vld <= '0;
      e_lck <= '0;
    end else begin
      e_vld <= e_vld & ~e_exp;
      if (i_alloc) e_vld[i_free] <= 1'b1;
      if (d_take) e_lck[d_hidx] <= 1'b1;
      if (d_done) begin
        e_vld[d_idx] <= 1'b0;
        e_lck[d_idx] <= 1'b0;
      end
    end
  end

  // Entry payload fields: allocate or aggregate the face mask.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (i_alloc) begin
        e_pfx[i_free]  <= i_pfx;
        e_len[i_free]  <= i_len;
        e_mask[i_free] <= face_bit;
      end else if (i_agg) begin
        e_mask[i_idx] <= e_mask[i_idx] | face_bit;
      end
    end
  end

`ifdef PIT_TIMEOUT_EN
  logic [15:0] e_age [ENTRIES];

  // Entry ages run only while the entry is waiting for data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst) begin
        e_age[i] <= '0;
      end else if (i_alloc && i_free == IW'(i)) begin
        e_age[i] <= '0;
      end else if (e_vld[i] && !e_lck[i]) begin
        e_age[i] <= e_age[i] + 16'd1;
      end
    end
  end

  // Expired entries vanish from lookups this cycle.
  always_comb begin
    e_exp = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      e_exp[i] = e_vld[i] && !e_lck[i]
                 && e_age[i] == 16'(LIFETIME);
    end
  end
`else
  logic unused_life;

  assign e_exp       = '0;
  assign unused_life = |16'(LIFETIME);
`endif

endmodule
